// File: rtl/fre_sel_ramp.sv
// fre_sel_ramp -- run-time programmable DDS frequency selector with slew limit.
//
// Holds a writable table of 2^SEL_W phase increments. `sel` chooses the
// target entry; the registered output `inc` walks toward the target by at
// most STEP every TICK_DIV clocks, so the downstream phase accumulator never
// sees a frequency jump.
//
// Configuration macro: FRE_SEL_RAMP_EN
//   defined   : slew-limited ramp (tick counter, STEP/TICK_DIV in use)
//   undefined : inc follows target one cycle later, no ramp logic
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   sel      in  SEL_W  table entry selecting the target increment
//   wr_en    in  1      table write strobe
//   wr_addr  in  SEL_W  table write address
//   wr_data  in  W      increment to write
//   inc      out W      registered phase increment to the accumulator
//   busy     out 1      high while inc differs from target (combinational)
//   done     out 1      one-cycle pulse when inc first reaches target
module fre_sel_ramp #(
  parameter int             W        = 32,
  parameter int             SEL_W    = 3,
  parameter int             TICK_DIV = 1024,
  parameter logic [W-1:0]   STEP     = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     inc,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = 32'd1 << SEL_W;

  logic [W-1:0] table_q [DEPTH];
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] inc_q, inc_d;
  logic         done_q, done_d;

  // Increment table: cleared on reset, written by the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Next target; a write to the selected entry bypasses the table so it
  // lands in target with the same latency as a sel change.
  always_comb begin
    target_d = table_q[sel];
    if (wr_en && (wr_addr == sel)) begin
      target_d = wr_data;
    end else begin
      target_d = table_q[sel];
    end
  end

`ifdef FRE_SEL_RAMP_EN
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;
  logic [W-1:0]     diff_s;

  // Free-running tick divider, wraps at TICK_DIV-1.
  always_comb begin
    tick_s = (cnt_q == CNT_W'(TICK_DIV - 1));
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Slew-limited step; the difference is always larger minus smaller so it
  // never wraps, and the last step saturates exactly onto target.
  always_comb begin
    inc_d  = inc_q;
    diff_s = '0;
    if (tick_s && (target_q > inc_q)) begin
      diff_s = target_q - inc_q;
      inc_d  = (diff_s > STEP) ? (inc_q + STEP) : target_q;
    end else if (tick_s && (target_q < inc_q)) begin
      diff_s = inc_q - target_q;
      inc_d  = (diff_s > STEP) ? (inc_q - STEP) : target_q;
    end else begin
      inc_d  = inc_q;
      diff_s = '0;
    end
  end
`else
  logic unused_cfg_s;

  // Ramp removed: the output simply follows the target register.
  always_comb begin
    inc_d        = target_q;
    unused_cfg_s = ^{STEP, TICK_DIV[0]};
  end
`endif

  // done fires when the next state matches after a cycle of mismatch.
  always_comb begin
    done_d = (inc_d == target_d) && (inc_q != target_q);
  end

  // Target, output increment and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      inc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      inc_q    <= inc_d;
      done_q   <= done_d;
    end
  end

  assign inc  = inc_q;
  assign busy = (inc_q != target_q);
  assign done = done_q;

endmodule

// File: doc/fre_sel_ramp.md
# fre_sel_ramp

Parametrised successor to the fixed-table DDS frequency selectors. It holds a run-time-writable table of phase increments and selects one entry with `sel`. Its output steps toward the newly selected increment under a programmable slew limit, so the phase accumulator never sees a frequency jump. It sits between the control logic (switches or bus writes) and the DDS phase accumulator.

## Interface
- `W`, 32: increment width, matches the accumulator width.
- `SEL_W`, 3: select width; the table has 2^SEL_W entries.
- `TICK_DIV`, 1024: clock cycles per ramp step, ≥2.
- `STEP`, 32'h0000_1000: maximum increment change per ramp step, unsigned, nonzero.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sel`, in, SEL_W: table entry selecting the target frequency.
- `wr_en`, in, 1: table write strobe.
- `wr_addr`, in, SEL_W: table write address.
- `wr_data`, in, W: increment to write.
- `inc`, out, W: registered phase increment driven to the accumulator.
- `busy`, out, 1: high while `inc != target`.
- `done`, out, 1: one-cycle pulse on the first cycle `inc` equals `target` after a difference.

## Operation
- Table: 2^SEL_W × W registers. A write with `wr_en` updates `table[wr_addr]` at the clock edge.
- Target register: `target <= (wr_en && wr_addr==sel) ? wr_data : table[sel]`, every cycle. This write-through means a write to the selected entry reaches `target` with the same one-cycle latency as a `sel` change.
- Tick counter: free-running 0..TICK_DIV-1, wraps to 0. `tick` is high when count == TICK_DIV-1.
- States, implicit in the registers:
  - IDLE when `inc == target`.
  - RAMP otherwise.
- On `tick` in RAMP, all arithmetic is unsigned W-bit, and the difference is always computed as larger minus smaller, so it never wraps:
  - If `target > inc`: `inc <= (target-inc > STEP) ? inc+STEP : target`.
  - If `target < inc`: `inc <= (inc-target > STEP) ? inc-STEP : target`.
- Retarget mid-ramp: the ramp continues from the current `inc` toward the new `target`. Direction is re-evaluated at each tick; there is no restart and no overshoot.
- Target returns to the current `inc` mid-ramp: `busy` drops the cycle after `target` updates, and `done` pulses then.
- `busy` is combinational from `inc` and `target`.
- `done` is registered so that it is high exactly in the first cycle where `inc == target` following a cycle where they differed.
- Reset values:
  - all table entries, `target`, `inc`, and the tick counter = 0;
  - `busy` = 0, `done` = 0.
- Reset mid-ramp returns everything to reset values at that edge; the ramp is abandoned.

## Timing
- `sel` or write change sampled at edge N: `target` valid after N+1.
- First step at the next `tick` edge after N+1, i.e. 1..TICK_DIV cycles later.
- A full ramp takes ceil(|Δ|/STEP) ticks. The last step saturates exactly onto `target`.
- `done` coincides with the cycle `inc` first equals `target`.
- `inc` changes only on tick edges (ramp mode), so it is stable for at least TICK_DIV cycles.

## Configuration
- `FRE_SEL_RAMP_EN` defined: slew-limited ramp as described. The tick counter and `STEP`/`TICK_DIV` logic are present.
- Not defined: `inc <= target` every cycle. The tick counter and ramp logic are removed, and `STEP` and `TICK_DIV` are ignored.
  - `inc` follows a `sel` change 2 cycles after the edge.
  - `busy` is high for at most one cycle.
  - `done` pulses in the cycle `inc` takes the new value.
  - Interface is unchanged.

## Test plan
Bench parameters: W=32, SEL_W=3, TICK_DIV=4, STEP=32'h100, `FRE_SEL_RAMP_EN` defined unless stated.
- Reset: assert `rst` 2 cycles → `inc`=0, `busy`=0, `done`=0. `sel`=0..7 each give `target`=0.
- Up-ramp: write table[1]=0x400, set `sel`=1 → `inc` goes 0x100, 0x200, 0x300, 0x400 on four consecutive ticks, 4 cycles apart. `done` pulses once with `inc`=0x400, then `busy`=0.
- Saturating down-ramp: table[2]=0x250, from `inc`=0x400 set `sel`=2 → `inc` goes 0x300, then 0x250. `done` pulses once.
- Mid-ramp retarget: ramping 0→0x400, at `inc`=0x200 set `sel`=0 (table[0]=0) → `inc` goes 0x100, 0x000. `done` pulses exactly once, and 0x300 never appears.
- Write-through: `sel`=3, single-cycle `wr_en` with `wr_addr`=3, `wr_data`=0x80 → `target`=0x80 one cycle later. A mid-ramp `rst` → `inc`=0 at the next edge, with no `done`.
- Macro undefined: table[4]=0x12345678, `sel`=4 → `inc`=0x12345678 exactly 2 cycles after the `sel` edge. `done` is high that cycle only.
